// File: rtl/axi_node_pkg.sv
// Shared types and constants for the AXI node master-port path.
// Payload field widths here are the defaults the node is built with.
package axi_node_pkg;

  localparam int AW_ADDR_W  = 32;
  localparam int AW_ID_IN_W = 4;
  localparam int AW_USER_W  = 6;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } aw_state_e;

  // AW payload without the ID; the ID is widened separately on the master side
  typedef struct packed {
    logic [AW_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           region;
    logic [AW_USER_W-1:0] user;
    logic [3:0]           qos;
  } aw_payload_t;

endpackage

// File: rtl/axi_aw_rr_arbiter.sv
// Round-robin pointer and wrap-around priority search over the slave AW requests.
// Winner outputs are zero unless the capture strobe is high.
module axi_aw_rr_arbiter #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_W       = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_TARG_PORT-1:0] i_req,
  input  logic                   i_cap,
  output logic [LOG_W-1:0]       o_bin,
  output logic [N_TARG_PORT-1:0] o_oh
);

  logic [LOG_W-1:0]       r_last;
  logic [LOG_W-1:0]       w_bin;
  logic [N_TARG_PORT-1:0] w_oh;
  logic                   w_found;

  // First request strictly after the last grant, wrapping back to it last
  always_comb begin
    w_found = 1'b0;
    w_bin   = '0;
    for (int k = 1; k <= N_TARG_PORT; k++) begin
      if (!w_found && i_req[(int'(r_last) + k) % N_TARG_PORT]) begin
        w_found = 1'b1;
        w_bin   = LOG_W'((int'(r_last) + k) % N_TARG_PORT);
      end
    end
    w_oh = w_found ? (N_TARG_PORT'(1) << w_bin) : '0;
  end

  assign o_bin = i_cap ? w_bin : '0;
  assign o_oh  = i_cap ? w_oh  : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= LOG_W'(N_TARG_PORT - 1);
    end else if (i_cap) begin
      r_last <= w_bin;
    end
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// Round-robin AW arbiter with one output register stage; pushes the winner's
// routing word into the write-data ID FIFO on each accepted AW.
//   state  | meaning
//   S_IDLE | output register empty, awvalid_o low
//   S_HOLD | payload held, awvalid_o high until awready_i
module axi_aw_arbiter
  import axi_node_pkg::*;
#(
  parameter int N_TARG_PORT   = 7,
  parameter int LOG_N_TARG    = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1,
  parameter int AXI_ADDRESS_W = AW_ADDR_W,
  parameter int AXI_ID_IN     = AW_ID_IN_W,
  parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG,
  parameter int AXI_USER_W    = AW_USER_W
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic [N_TARG_PORT*AXI_ID_IN-1:0]     awid_i,
  input  logic [N_TARG_PORT*AXI_ADDRESS_W-1:0] awaddr_i,
  input  logic [N_TARG_PORT*8-1:0]             awlen_i,
  input  logic [N_TARG_PORT*3-1:0]             awsize_i,
  input  logic [N_TARG_PORT*2-1:0]             awburst_i,
  input  logic [N_TARG_PORT-1:0]               awlock_i,
  input  logic [N_TARG_PORT*4-1:0]             awcache_i,
  input  logic [N_TARG_PORT*3-1:0]             awprot_i,
  input  logic [N_TARG_PORT*4-1:0]             awregion_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]    awuser_i,
  input  logic [N_TARG_PORT*4-1:0]             awqos_i,
  input  logic [N_TARG_PORT-1:0]               awvalid_i,
  output logic [N_TARG_PORT-1:0]               awready_o,

  output logic [AXI_ID_OUT-1:0]                awid_o,
  output logic [AXI_ADDRESS_W-1:0]             awaddr_o,
  output logic [7:0]                           awlen_o,
  output logic [2:0]                           awsize_o,
  output logic [1:0]                           awburst_o,
  output logic                                 awlock_o,
  output logic [3:0]                           awcache_o,
  output logic [2:0]                           awprot_o,
  output logic [3:0]                           awregion_o,
  output logic [AXI_USER_W-1:0]                awuser_o,
  output logic [3:0]                           awqos_o,
  output logic                                 awvalid_o,
  input  logic                                 awready_i,

  output logic                                 push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]    ID_o,
  input  logic                                 grant_FIFO_ID_i
);

  aw_state_e              r_state;
  logic                   r_awvalid;
  aw_payload_t            r_payload;
  logic [AXI_ID_OUT-1:0]  r_awid;

  logic                   w_cap;
  logic [LOG_N_TARG-1:0]  w_bin;
  logic [N_TARG_PORT-1:0] w_oh;
  aw_payload_t            w_pl;
  logic [AXI_ID_OUT-1:0]  w_awid;
  int                     w_sel;

  // Reset gates capture so no handshake or push leaks out during reset
  assign w_cap = !rst && ((r_state == S_IDLE) || awready_i) &&
                 grant_FIFO_ID_i && (|awvalid_i);

  axi_aw_rr_arbiter #(
    .N_TARG_PORT (N_TARG_PORT),
    .LOG_W       (LOG_N_TARG)
  ) u_rr (
    .i_clk (clk),
    .i_rst (rst),
    .i_req (awvalid_i),
    .i_cap (w_cap),
    .o_bin (w_bin),
    .o_oh  (w_oh)
  );

  always_comb begin
    w_sel         = int'(w_bin);
    w_pl          = '0;
    w_pl.addr     = awaddr_i  [w_sel*AXI_ADDRESS_W +: AXI_ADDRESS_W];
    w_pl.len      = awlen_i   [w_sel*8 +: 8];
    w_pl.size     = awsize_i  [w_sel*3 +: 3];
    w_pl.burst    = awburst_i [w_sel*2 +: 2];
    w_pl.lock     = awlock_i  [w_sel];
    w_pl.cache    = awcache_i [w_sel*4 +: 4];
    w_pl.prot     = awprot_i  [w_sel*3 +: 3];
    w_pl.region   = awregion_i[w_sel*4 +: 4];
    w_pl.user     = awuser_i  [w_sel*AXI_USER_W +: AXI_USER_W];
    w_pl.qos      = awqos_i   [w_sel*4 +: 4];
    w_awid        = {w_bin, awid_i[w_sel*AXI_ID_IN +: AXI_ID_IN]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_payload <= '0;
      r_awid    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cap) begin
            r_state   <= S_HOLD;
            r_awvalid <= 1'b1;
            r_payload <= w_pl;
            r_awid    <= w_awid;
          end
        end
        S_HOLD: begin
          if (awready_i) begin
            if (w_cap) begin
              r_payload <= w_pl;
              r_awid    <= w_awid;
            end else begin
              r_state   <= S_IDLE;
              r_awvalid <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_awvalid <= 1'b0;
        end
      endcase
    end
  end

  assign awready_o  = w_oh;
  assign push_ID_o  = w_cap;
  assign ID_o       = {w_bin, w_oh};

  assign awvalid_o  = r_awvalid;
  assign awid_o     = r_awid;
  assign awaddr_o   = r_payload.addr;
  assign awlen_o    = r_payload.len;
  assign awsize_o   = r_payload.size;
  assign awburst_o  = r_payload.burst;
  assign awlock_o   = r_payload.lock;
  assign awcache_o  = r_payload.cache;
  assign awprot_o   = r_payload.prot;
  assign awregion_o = r_payload.region;
  assign awuser_o   = r_payload.user;
  assign awqos_o    = r_payload.qos;

endmodule
